// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle
// results queue in a small FIFO and a starvation counter forces a one-cycle stall.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_we_mem_wb,
  input  logic [ADDR_W-1:0]             pipe_rd_mem_wb,
  input  logic [DATA_W-1:0]             pipe_data_mem_wb,
  input  logic                          mc_valid,
  input  logic [ADDR_W-1:0]             mc_rd,
  input  logic [DATA_W-1:0]             mc_data,
  output logic                          mc_ready,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          stall_pipe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t            state;
  logic [SW-1:0]     starve;
  logic [SW-1:0]     starve_inc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

  logic              pipe_req;
  logic              fifo_nonempty;
  logic              grant_fifo;
  logic              push;
  logic [ADDR_W-1:0] gnt_rd;
  logic [DATA_W-1:0] gnt_data;

  always_comb begin
    mc_ready      = fifo_count < CNT_W'(FIFO_DEPTH);
    stall_pipe    = (state == FORCE);
    // In FORCE pipe_req is low, so the FIFO head wins without a separate path.
    pipe_req      = pipe_we_mem_wb && (state == NORMAL);
    fifo_nonempty = (fifo_count != '0);
    grant_fifo    = !pipe_req && fifo_nonempty;
    push          = mc_valid && mc_ready;
    starve_inc    = starve + SW'(1);
    gnt_rd        = pipe_req ? pipe_rd_mem_wb   : fifo_rd[rd_ptr];
    gnt_data      = pipe_req ? pipe_data_mem_wb : fifo_data[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mc_rd;
      fifo_data[wr_ptr] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      starve     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (grant_fifo)
        rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(grant_fifo);

      if (pipe_req || grant_fifo) begin
        rf_we    <= (gnt_rd != '0);
        rf_waddr <= gnt_rd;
        rf_wdata <= gnt_data;
      end else begin
        rf_we    <= 1'b0;
      end

      if (state == NORMAL) begin
        if (pipe_req && fifo_nonempty) begin
          if (starve_inc == SW'(STARVE_LIMIT)) begin
            starve <= '0;
            state  <= FORCE;
          end else begin
            starve <= starve_inc;
          end
        end else begin
          starve <= '0;
        end
      end else begin
        starve <= '0;
        state  <= NORMAL;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_we_mem_wb = 1'b0;
  logic [4:0]  pipe_rd_mem_wb = '0;
  logic [31:0] pipe_data_mem_wb = '0;
  logic        mc_valid = 1'b0;
  logic [4:0]  mc_rd = '0;
  logic [31:0] mc_data = '0;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_pipe;
  logic [1:0]  fifo_count;

  int tests = 0;
  int fails = 0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_we_mem_wb(pipe_we_mem_wb), .pipe_rd_mem_wb(pipe_rd_mem_wb),
    .pipe_data_mem_wb(pipe_data_mem_wb),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_pipe(stall_pipe), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; pipe_we_mem_wb = 1'b1; pipe_rd_mem_wb = 5'd9; pipe_data_mem_wb = 32'hDEAD;
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'hBEEF;
    tick; tick;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", rf_we); end
    tests++; if (rf_waddr !== 5'd0) begin fails++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
    tests++; if (rf_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
    tests++; if (fifo_count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    tests++; if (stall_pipe !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall_pipe); end
    tests++; if (mc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", mc_ready); end
    reset = 1'b0; pipe_we_mem_wb = 1'b0; mc_valid = 1'b0;
  endtask

  task automatic test_pipe_write;
    pipe_we_mem_wb = 1'b1; pipe_rd_mem_wb = 5'd3; pipe_data_mem_wb = 32'h11;
    tick;
    pipe_we_mem_wb = 1'b0;
    tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin fails++;
      $display("FAIL pipe_write got we=%b a=%0d d=%h exp we=1 a=3 d=11", rf_we, rf_waddr, rf_wdata); end
    tests++; if (stall_pipe !== 1'b0) begin fails++; $display("FAIL pipe_stall got %b exp 0", stall_pipe); end
    tick;
    tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h11}) begin fails++;
      $display("FAIL pipe_hold got we=%b a=%0d d=%h exp we=0 a=3 d=11", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_mc_write;
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'hABCD;
    tick;
    mc_valid = 1'b0;
    tests++; if (fifo_count !== 2'd1) begin fails++; $display("FAIL mc_count1 got %0d exp 1", fifo_count); end
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL mc_nobypass got we=%b exp 0", rf_we); end
    tick;
    tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hABCD}) begin fails++;
      $display("FAIL mc_write got we=%b a=%0d d=%h exp we=1 a=7 d=abcd", rf_we, rf_waddr, rf_wdata); end
    tests++; if (fifo_count !== 2'd0) begin fails++; $display("FAIL mc_count0 got %0d exp 0", fifo_count); end
  endtask

  task automatic test_back_to_back;
    mc_valid = 1'b1; mc_rd = 5'd8; mc_data = 32'h80;
    tick;
    mc_rd = 5'd9; mc_data = 32'h90;
    tick;
    mc_valid = 1'b0;
    tests++; if (fifo_count !== 2'd1) begin fails++; $display("FAIL b2b_count got %0d exp 1", fifo_count); end
    tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h80}) begin fails++;
      $display("FAIL b2b_first got we=%b a=%0d d=%h exp we=1 a=8 d=80", rf_we, rf_waddr, rf_wdata); end
    tick;
    tests++; if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 5'd9, 32'h90, 2'd0}) begin fails++;
      $display("FAIL b2b_second got we=%b a=%0d d=%h cnt=%0d exp we=1 a=9 d=90 cnt=0", rf_we, rf_waddr, rf_wdata, fifo_count); end
  endtask

  task automatic test_starvation;
    pipe_we_mem_wb = 1'b1; pipe_rd_mem_wb = 5'd2; pipe_data_mem_wb = 32'h22;
    mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'h55;
    tick;
    mc_valid = 1'b0;
    tests++; if ({rf_waddr, fifo_count} !== {5'd2, 2'd1}) begin fails++;
      $display("FAIL starve_start got a=%0d cnt=%0d exp a=2 cnt=1", rf_waddr, fifo_count); end
    for (int i = 1; i <= 4; i++) begin
      tick;
      tests++; if ({rf_we, rf_waddr, stall_pipe} !== {1'b1, 5'd2, (i == 4)}) begin fails++;
        $display("FAIL starve_pipe%0d got we=%b a=%0d stall=%b exp we=1 a=2 stall=%b", i, rf_we, rf_waddr, stall_pipe, (i == 4)); end
    end
    tick;
    tests++; if ({rf_we, rf_waddr, rf_wdata, stall_pipe, fifo_count} !== {1'b1, 5'd5, 32'h55, 1'b0, 2'd0}) begin fails++;
      $display("FAIL starve_force got we=%b a=%0d d=%h stall=%b cnt=%0d exp we=1 a=5 d=55 stall=0 cnt=0", rf_we, rf_waddr, rf_wdata, stall_pipe, fifo_count); end
    tick;
    pipe_we_mem_wb = 1'b0;
    tests++; if ({rf_waddr, stall_pipe} !== {5'd2, 1'b0}) begin fails++;
      $display("FAIL starve_resume got a=%0d stall=%b exp a=2 stall=0", rf_waddr, stall_pipe); end
  endtask

  task automatic test_fifo_full;
    pipe_we_mem_wb = 1'b1; pipe_rd_mem_wb = 5'd2; pipe_data_mem_wb = 32'h22;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA0;
    tick;
    mc_rd = 5'd11; mc_data = 32'hA1;
    tick;
    mc_rd = 5'd12; mc_data = 32'hA2;
    tests++; if ({fifo_count, mc_ready} !== {2'd2, 1'b0}) begin fails++;
      $display("FAIL full_state got cnt=%0d ready=%b exp cnt=2 ready=0", fifo_count, mc_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++; if (fifo_count !== 2'd2) begin fails++; $display("FAIL full_nopush%0d got cnt=%0d exp 2", i, fifo_count); end
    end
    tests++; if (stall_pipe !== 1'b1) begin fails++; $display("FAIL full_force1 got stall=%b exp 1", stall_pipe); end
    tick;
    mc_valid = 1'b0;
    tests++; if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 5'd10, 32'hA0, 2'd1}) begin fails++;
      $display("FAIL full_pop1 got we=%b a=%0d d=%h cnt=%0d exp we=1 a=10 d=a0 cnt=1", rf_we, rf_waddr, rf_wdata, fifo_count); end
    for (int i = 0; i < 4; i++) tick;
    tests++; if (stall_pipe !== 1'b1) begin fails++; $display("FAIL full_force2 got stall=%b exp 1", stall_pipe); end
    tick;
    pipe_we_mem_wb = 1'b0;
    tests++; if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 5'd11, 32'hA1, 2'd0}) begin fails++;
      $display("FAIL full_pop2 got we=%b a=%0d d=%h cnt=%0d exp we=1 a=11 d=a1 cnt=0", rf_we, rf_waddr, rf_wdata, fifo_count); end
  endtask

  task automatic test_r0;
    pipe_we_mem_wb = 1'b1; pipe_rd_mem_wb = 5'd0; pipe_data_mem_wb = 32'h99;
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h77;
    tick;
    pipe_we_mem_wb = 1'b0; mc_valid = 1'b0;
    tests++; if ({rf_we, rf_wdata, fifo_count} !== {1'b0, 32'h99, 2'd1}) begin fails++;
      $display("FAIL r0_pipe got we=%b d=%h cnt=%0d exp we=0 d=99 cnt=1", rf_we, rf_wdata, fifo_count); end
    tick;
    tests++; if ({rf_we, rf_wdata, fifo_count} !== {1'b0, 32'h77, 2'd0}) begin fails++;
      $display("FAIL r0_mc got we=%b d=%h cnt=%0d exp we=0 d=77 cnt=0", rf_we, rf_wdata, fifo_count); end
  endtask

  task automatic test_reset_in_force;
    pipe_we_mem_wb = 1'b1; pipe_rd_mem_wb = 5'd6; pipe_data_mem_wb = 32'h66;
    mc_valid = 1'b1; mc_rd = 5'd13; mc_data = 32'hC0;
    tick; tick;
    mc_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    tests++; if ({stall_pipe, fifo_count} !== {1'b1, 2'd2}) begin fails++;
      $display("FAIL rf_pre got stall=%b cnt=%0d exp stall=1 cnt=2", stall_pipe, fifo_count); end
    reset = 1'b1;
    tick;
    reset = 1'b0; pipe_we_mem_wb = 1'b0;
    tests++; if ({fifo_count, stall_pipe, rf_we, rf_waddr} !== {2'd0, 1'b0, 1'b0, 5'd0}) begin fails++;
      $display("FAIL rf_reset got cnt=%0d stall=%b we=%b a=%0d exp cnt=0 stall=0 we=0 a=0", fifo_count, stall_pipe, rf_we, rf_waddr); end
    mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h1234;
    tick;
    mc_valid = 1'b0;
    tests++; if (fifo_count !== 2'd1) begin fails++; $display("FAIL rf_push got cnt=%0d exp 1", fifo_count); end
    tick;
    tests++; if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 5'd9, 32'h1234, 2'd0}) begin fails++;
      $display("FAIL rf_after got we=%b a=%0d d=%h cnt=%0d exp we=1 a=9 d=1234 cnt=0", rf_we, rf_waddr, rf_wdata, fifo_count); end
  endtask

  initial begin
    test_reset;
    test_pipe_write;
    test_mc_write;
    test_back_to_back;
    test_starvation;
    test_fifo_full;
    test_r0;
    test_reset_in_force;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline MEM/WB writeback and a multi-cycle unit (mult/div, any long-latency producer).
- The pipeline has priority. Multi-cycle results queue in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so that queued results always retire.
- Sits between the write-back mux output and the register file write port.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, multi-cycle result buffer entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive lost arbitrations before a forced stall (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pipe_we_mem_wb  input  1  pipeline writeback enable
- pipe_rd_mem_wb  input  ADDR_W  pipeline destination register
- pipe_data_mem_wb  input  DATA_W  pipeline writeback data (already mux-selected)
- mc_valid  input  1  multi-cycle result offered
- mc_rd  input  ADDR_W  multi-cycle destination register
- mc_data  input  DATA_W  multi-cycle result data
- mc_ready  output  1  FIFO can accept (count < FIFO_DEPTH)
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  ADDR_W  register-file write address (registered)
- rf_wdata  output  DATA_W  register-file write data (registered)
- stall_pipe  output  1  freeze MEM/WB and earlier stages this cycle
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:

Reset:
- reset=1 at a rising edge clears: rf_we, rf_waddr, rf_wdata, fifo_count, the starvation counter, and the state (to NORMAL).
- FIFO contents are discarded. A reset mid-operation drops pending results; the producer is reset by the same signal.

FSM states:
- NORMAL: stall_pipe=0.
- FORCE: stall_pipe=1. stall_pipe is a Moore output of the state.

FIFO:
- Push when mc_valid && mc_ready. mc_ready depends only on registered count, so it is 0 when full.
- Pop on a FIFO grant. Push and pop may occur in the same cycle; count is then unchanged.
- No bypass: an entry pushed in cycle N is grantable in cycle N+1 at the earliest.
- Entries retire in push order.

Grant logic (per cycle, combinational):
- pipe_req = pipe_we_mem_wb && state==NORMAL.
- NORMAL: pipe_req -> grant pipeline; else count>0 -> grant FIFO head; else no grant.
- FORCE: grant FIFO head. count>0 is guaranteed. Pipeline inputs are ignored, because the frozen MEM/WB stage re-presents the same write next cycle.

Write port:
- Write port outputs are registered, latency 1. Next rf_we = granted && granted_rd != 0.
- rf_waddr and rf_wdata take the granted source values.
- With no grant, rf_we=0 and rf_waddr/rf_wdata hold.
- Writes to r0 consume the grant (FIFO pops) but produce rf_we=0.

Starvation counter (NORMAL only):
- count>0 && pipeline granted: increment.
- FIFO granted, or count==0: clear to 0.
- If the increment would equal STARVE_LIMIT: counter clears, next state FORCE.

FORCE:
- Lasts exactly one cycle: pops one entry, then next state NORMAL, counter = 0.

Simultaneous events:
- A push in the FORCE cycle is allowed if mc_ready=1.
- reset has priority over all events.

Test Plan:
1. Reset, then pipe_we=1, rd=3, data=0x11 with no mc traffic -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x11; stall_pipe=0.
2. Pipeline idle; mc_valid=1, rd=7, data=0xABCD for one cycle -> fifo_count=1 next cycle; write of 7/0xABCD appears the cycle after; fifo_count returns to 0.
3. One mc entry (rd=5) queued while pipe_we=1 continuously (rd=2) -> 4 pipeline writes; the cycle after the 4th grant has stall_pipe=1 and the next-cycle write is rd=5; then pipeline writes resume with stall_pipe=0.
4. mc_valid held high with pipeline saturating -> fifo_count reaches 2 and mc_ready=0; no third push accepted; entries retire in push order at the forced stalls.
5. Pipeline write rd=0 and mc entry rd=0 -> both consume their grant, rf_we stays 0, fifo_count decrements.
6. Assert reset with fifo_count=2 during FORCE -> next cycle fifo_count=0, stall_pipe=0, rf_we=0; a later mc push is written normally.
